// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, ALU function encodings, decode FSM states
// and the control bundle produced by the opcode decoder.
package cpu_pkg;

  localparam int unsigned OpW = 8;

  localparam logic [OpW-1:0] OpLoadi = 8'h00;
  localparam logic [OpW-1:0] OpMov   = 8'h01;
  localparam logic [OpW-1:0] OpAdd   = 8'h02;
  localparam logic [OpW-1:0] OpSub   = 8'h03;
  localparam logic [OpW-1:0] OpAnd   = 8'h04;
  localparam logic [OpW-1:0] OpOr    = 8'h05;
  localparam logic [OpW-1:0] OpJ     = 8'h06;
  localparam logic [OpW-1:0] OpBeq   = 8'h07;

  typedef enum logic [2:0] {
    AluPass = 3'b000,
    AluAdd  = 3'b001,
    AluAnd  = 3'b010,
    AluOr   = 3'b011
  } aluop_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDecode = 2'd1,
    StWb     = 2'd2
  } state_e;

  typedef struct packed {
    aluop_e aluop;
    logic   immsel;
    logic   negsel;
    logic   write;
    logic   jump;
    logic   branch;
    logic   illegal;
  } ctrl_t;

  // Control-flow opcodes carry a word offset in the dest/offset byte.
  function automatic logic has_offset(input ctrl_t c);
    return c.jump | c.branch;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode to control-bundle lookup; undefined opcodes raise
// only the illegal flag.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [OpW-1:0] opcode,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OpLoadi: begin
        ctrl.aluop  = AluPass;
        ctrl.immsel = 1'b1;
        ctrl.write  = 1'b1;
      end
      OpMov: begin
        ctrl.aluop = AluPass;
        ctrl.write = 1'b1;
      end
      OpAdd: begin
        ctrl.aluop = AluAdd;
        ctrl.write = 1'b1;
      end
      OpSub: begin
        ctrl.aluop  = AluAdd;
        ctrl.negsel = 1'b1;
        ctrl.write  = 1'b1;
      end
      OpAnd: begin
        ctrl.aluop = AluAnd;
        ctrl.write = 1'b1;
      end
      OpOr: begin
        ctrl.aluop = AluOr;
        ctrl.write = 1'b1;
      end
      OpJ: begin
        ctrl.jump = 1'b1;
      end
      // beq compares by subtracting operands in the ALU
      OpBeq: begin
        ctrl.aluop  = AluAdd;
        ctrl.negsel = 1'b1;
        ctrl.branch = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// Instruction decode stage: IDLE/DECODE/WB handshake FSM, registered decode
// outputs, single-cycle WB pulses and a wrapping retired-instruction counter.
module decode_unit
  import cpu_pkg::*;
#(
  parameter int unsigned IW = 32,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic [IW-1:0] INSTRUCTION,
  input  logic          INSTR_VALID,
  output logic          INSTR_READY,
  output logic [AW-1:0] OUT1ADDRESS,
  output logic [AW-1:0] OUT2ADDRESS,
  output logic [AW-1:0] INADDRESS,
  output logic          WRITE,
  output logic [DW-1:0] IMMEDIATE,
  output logic [2:0]    ALUOP,
  output logic          IMMSEL,
  output logic          NEGSEL,
  output logic          JUMP,
  output logic          BRANCH,
  output logic [DW-1:0] OFFSET,
  output logic          ILLEGAL,
  output logic [7:0]    RETIRED
);

  state_e        state_q, state_d;
  logic          armed_q;
  logic          accept;
  ctrl_t         dec_ctrl;
  ctrl_t         ctrl_q;
  logic [AW-1:0] dest_q, src1_q, src2_q;
  logic [DW-1:0] imm_q, offset_q;
  logic [7:0]    retired_q;

  opcode_decoder u_opcode_decoder (
    .opcode (INSTRUCTION[IW-1 -: OpW]),
    .ctrl   (dec_ctrl)
  );

  // armed_q holds off READY until the first edge after reset release, so the
  // releasing edge can never complete a handshake.
  assign INSTR_READY = (state_q == StIdle) && armed_q;
  assign accept      = INSTR_VALID && INSTR_READY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StDecode;
      StDecode: state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ctrl_q   <= '0;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      imm_q    <= '0;
      offset_q <= '0;
    end else if (accept) begin
      ctrl_q   <= dec_ctrl;
      dest_q   <= INSTRUCTION[16 +: AW];
      src1_q   <= INSTRUCTION[8 +: AW];
      src2_q   <= INSTRUCTION[0 +: AW];
      imm_q    <= INSTRUCTION[0 +: DW];
      offset_q <= has_offset(dec_ctrl) ? INSTRUCTION[16 +: DW] : '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      retired_q <= '0;
    end else if (state_q == StWb && !ctrl_q.illegal) begin
      retired_q <= retired_q + 8'd1;
    end
  end

  assign OUT1ADDRESS = src1_q;
  assign OUT2ADDRESS = src2_q;
  assign INADDRESS   = dest_q;
  assign IMMEDIATE   = imm_q;
  assign ALUOP       = ctrl_q.aluop;
  assign IMMSEL      = ctrl_q.immsel;
  assign NEGSEL      = ctrl_q.negsel;
  assign OFFSET      = offset_q;
  assign RETIRED     = retired_q;

  // Pulses are gated by the WB state so an async reset kills them at once.
  assign WRITE   = (state_q == StWb) && ctrl_q.write;
  assign JUMP    = (state_q == StWb) && ctrl_q.jump;
  assign BRANCH  = (state_q == StWb) && ctrl_q.branch;
  assign ILLEGAL = (state_q == StWb) && ctrl_q.illegal;

  logic unused_bits;
  assign unused_bits = ^{INSTRUCTION[15:11], INSTRUCTION[7:3]};

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 Parameter: IW, 32, instruction word width.
REQ-002 Parameter: DW, 8, register data / immediate width.
REQ-003 Parameter: AW, 3, register address width.
REQ-004 Clock is CLK and reset is RESETN: one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  rising-edge system clock.
REQ-006 RESETN  in  1  asynchronous active-low reset.
REQ-007 INSTRUCTION  in  IW  word from fetch: [31:24] opcode, [18:16] dest, [10:8] src1, [2:0] src2, [7:0] immediate/offset.
REQ-008 INSTR_VALID  in  1  fetch presents a valid INSTRUCTION.
REQ-009 INSTR_READY  out  1  unit accepts an instruction this cycle.
REQ-010 OUT1ADDRESS, OUT2ADDRESS  out  AW each  register-file read addresses (src1, src2).
REQ-011 INADDRESS  out  AW  register-file write address (dest).
REQ-012 WRITE  out  1  register-file write enable, one-cycle pulse.
REQ-013 IMMEDIATE  out  DW  immediate operand; ALUOP  out  3  ALU function; IMMSEL  out  1  ALU operand2 = IMMEDIATE; NEGSEL  out  1  negate operand2.
REQ-014 JUMP, BRANCH  out  1 each  one-cycle control pulses; OFFSET  out  DW  signed word offset.
REQ-015 ILLEGAL  out  1  one-cycle pulse for an undefined opcode; RETIRED  out  8  retired-instruction count.

Function
REQ-016 FSM states: IDLE, DECODE, WB; transitions IDLE->DECODE on INSTR_VALID&INSTR_READY, DECODE->WB unconditionally, WB->IDLE unconditionally.
REQ-017 INSTR_READY = 1 only in IDLE; handshake completes on a rising edge with INSTR_VALID=1 and INSTR_READY=1; INSTRUCTION latched at that edge.
REQ-018 INSTR_VALID outside IDLE is ignored; upstream holds the word; throughput one instruction per 3 cycles.
REQ-019 Decode table: 0x00 loadi (ALUOP 000, IMMSEL 1, write); 0x01 mov (000, write); 0x02 add (001, write); 0x03 sub (001, NEGSEL 1, write); 0x04 and (010, write); 0x05 or (011, write); 0x06 j (JUMP); 0x07 beq (001, NEGSEL 1, BRANCH); others illegal.
REQ-020 All decode outputs registered: valid from first cycle of DECODE, held stable through WB and IDLE until next accept.
REQ-021 WRITE = 1 during WB only, for write-class opcodes, with INADDRESS stable, so the register file captures on the edge ending WB.
REQ-022 JUMP/BRANCH pulse high during WB only; OFFSET = INSTRUCTION[23:16] for j/beq, else 0.
REQ-023 Illegal opcode: WRITE, JUMP, BRANCH stay 0; ILLEGAL pulses during WB; FSM still returns to IDLE.
REQ-024 RETIRED increments by 1 on the WB->IDLE edge for every legal instruction; 255 wraps to 0; unchanged for illegal.
REQ-025 Address fields use low AW bits only; upper bits of byte fields ignored, not flagged.

Reset
REQ-026 RESETN low forces, asynchronously: state IDLE, all outputs 0 except INSTR_READY=0 while RESETN low and 1 from first edge after release, RETIRED=0.
REQ-027 Reset mid-DECODE or mid-WB drops the instruction: no WRITE, JUMP, BRANCH or ILLEGAL pulse, no RETIRED increment.
REQ-028 No handshake on the edge where RESETN deasserts.

Structure
REQ-029 Opcode constants, ALUOP encodings and the FSM state enum live in shared package cpu_pkg, reused by the ALU.
REQ-030 One sub-module, opcode_decoder (combinational opcode -> control bundle), instantiated once; FSM, latch and counter in decode_unit.

Verification
REQ-031 Reset then INSTRUCTION 0x00_05_00_2A loadi -> 2 cycles later WRITE=1 one cycle, INADDRESS=5, IMMEDIATE=0x2A, IMMSEL=1, ALUOP=000; RETIRED=1.
REQ-032 sub 0x03_02_01_03 -> OUT1ADDRESS=1, OUT2ADDRESS=3, NEGSEL=1, ALUOP=001, WRITE pulse INADDRESS=2.
REQ-033 beq 0x07_FE_04_06 -> BRANCH pulse in WB, OFFSET=0xFE, WRITE=0; j 0x06_03_00_00 -> JUMP pulse, OFFSET=0x03.
REQ-034 Opcode 0xFF -> ILLEGAL pulse in WB, no WRITE, RETIRED unchanged; INSTR_VALID held high continuously -> accepts every 3rd cycle only.
REQ-035 RESETN low during WB of add -> WRITE drops immediately, RETIRED=0, INSTR_READY=1 after release.
REQ-036 256 legal instructions -> RETIRED wraps to 0.
